// File: rtl/rr_arbiter8.sv
// rr_arbiter8 -- round-robin arbiter sharing one resource among 8 requesters.
//
// A rotating pointer selects where the request scan starts. The winner gets
// a registered one-hot grant plus its 3-bit index. The index is an OR-encoding
// of the one-hot grant. An owner keeps the grant until it drops its request,
// or until HOLD_LIMIT consecutive cycles have elapsed (HOLD_LIMIT = 0 means
// no limit). Every release passes through one idle cycle before the next
// grant is issued.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req[7:0]   request lines, req[k] = requester k wants the resource
//   gnt[7:0]   registered one-hot grant, zero when there is no owner
//   gnt_idx    encoded index of the set gnt bit, zero when idle
//   gnt_valid  high while any gnt bit is set
//   forced     one-cycle pulse after a grant is revoked by HOLD_LIMIT
module rr_arbiter8 #(
    parameter int unsigned HOLD_LIMIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       forced
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q;
    logic [2:0] ptr_q;
    logic [7:0] hcnt_q;

    logic [7:0] win_oh_d;
    logic       limit_hit;

    // OR-based 8-to-3 encoder; only meaningful for one-hot or zero input.
    function automatic logic [2:0] enc8(input logic [7:0] oh);
        enc8[0] = oh[1] | oh[3] | oh[5] | oh[7];
        enc8[1] = oh[2] | oh[3] | oh[6] | oh[7];
        enc8[2] = oh[4] | oh[5] | oh[6] | oh[7];
    endfunction

    // The first set request at or after the pointer, wrapping modulo 8.
    always_comb begin
        logic       found;
        logic [2:0] idx;
        win_oh_d = '0;
        found    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr_q + 3'(i);
            if (!found && req[idx]) begin
                found         = 1'b1;
                win_oh_d[idx] = 1'b1;
            end
        end
    end

    assign limit_hit = (HOLD_LIMIT != 0) && (hcnt_q == 8'(HOLD_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hcnt_q    <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            forced    <= 1'b0;
        end else begin
            forced <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        gnt       <= win_oh_d;
                        gnt_idx   <= enc8(win_oh_d);
                        gnt_valid <= 1'b1;
                        hcnt_q    <= 8'd1;
                        state_q   <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req[gnt_idx] || limit_hit) begin
                        // A normal release and a forced release update the same state.
                        // The pointer moves past the owner, so a revoked requester
                        // competes in the scan like any other requester.
                        gnt       <= '0;
                        gnt_idx   <= '0;
                        gnt_valid <= 1'b0;
                        ptr_q     <= gnt_idx + 3'd1;
                        hcnt_q    <= '0;
                        forced    <= req[gnt_idx];
                        state_q   <= IDLE;
                    end else if (hcnt_q != 8'hFF) begin
                        hcnt_q <= hcnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
module tb_rr_arbiter8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [7:0]       req = 8'h00;
    logic [2:0][7:0]  gnt_w;
    logic [2:0][2:0]  idx_w;
    logic [2:0]       vld_w;
    logic [2:0]       frc_w;

    int errors = 0;
    int checks = 0;

    // Three instances share the same request bus. Instance 0 uses the default
    // limit of 16, instance 1 uses a limit of 4, and instance 2 has no limit.
    int lim [3] = '{16, 4, 0};

    // Reference model state: the current owner (-1 = none), the scan start
    // position, the number of cycles held, and the pending forced pulse.
    int m_owner [3];
    int m_ptr   [3];
    int m_hold  [3];
    bit m_frc   [3];

    always #5 clk = ~clk;

    rr_arbiter8 #(.HOLD_LIMIT(16)) u_d16 (.clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_w[0]), .gnt_idx(idx_w[0]), .gnt_valid(vld_w[0]), .forced(frc_w[0]));
    rr_arbiter8 #(.HOLD_LIMIT(4))  u_d4  (.clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_w[1]), .gnt_idx(idx_w[1]), .gnt_valid(vld_w[1]), .forced(frc_w[1]));
    rr_arbiter8 #(.HOLD_LIMIT(0))  u_d0  (.clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_w[2]), .gnt_idx(idx_w[2]), .gnt_valid(vld_w[2]), .forced(frc_w[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            m_owner[m] = -1; m_ptr[m] = 0; m_hold[m] = 0; m_frc[m] = 1'b0;
        end
    endtask

    task automatic model_step(input int m, input logic [7:0] r);
        m_frc[m] = 1'b0;
        if (m_owner[m] < 0) begin
            for (int k = 0; k < 8; k++) begin
                int c;
                c = (m_ptr[m] + k) % 8;
                if (m_owner[m] < 0 && r[c]) begin
                    m_owner[m] = c;
                    m_hold[m]  = 1;
                end
            end
        end else if (!r[m_owner[m]] || (lim[m] != 0 && m_hold[m] == lim[m])) begin
            m_frc[m]   = r[m_owner[m]];
            m_ptr[m]   = (m_owner[m] + 1) % 8;
            m_owner[m] = -1;
            m_hold[m]  = 0;
        end else begin
            m_hold[m] = (m_hold[m] >= 255) ? 255 : m_hold[m] + 1;
        end
    endtask

    task automatic check_all(input string tag);
        for (int m = 0; m < 3; m++) begin
            logic [7:0] eg;
            eg = (m_owner[m] < 0) ? 8'h00 : (8'h01 << m_owner[m]);
            chk({tag, "_gnt"},   32'(gnt_w[m]), 32'(eg));
            chk({tag, "_idx"},   32'(idx_w[m]), (m_owner[m] < 0) ? 32'd0 : 32'(m_owner[m]));
            chk({tag, "_valid"}, 32'(vld_w[m]), 32'(m_owner[m] >= 0));
            chk({tag, "_forced"}, 32'(frc_w[m]), 32'(m_frc[m]));
        end
    endtask

    // Inputs are stable across the edge; the model consumes the same sampled
    // request vector, and outputs are compared 1 ns after the edge.
    task automatic tick(input string tag);
        @(posedge clk);
        for (int m = 0; m < 3; m++) model_step(m, req);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int seq [$];

        // Reset state.
        #2;
        req = 8'h00;
        do_reset();
        tick("idle");

        // T1: single requester 2, held 3 granted cycles, then dropped.
        req = 8'h04;
        repeat (3) tick("t1_hold");
        req = 8'h00;
        repeat (2) tick("t1_rel");

        // T2: the scan from 3 picks 7; the wrapped pointer then picks 1.
        req = 8'h82;
        repeat (2) tick("t2_a");
        req = 8'h00;
        tick("t2_rel");
        req = 8'h82;
        repeat (2) tick("t2_b");
        req = 8'h00;
        repeat (2) tick("t2_end");

        // T3: fairness from reset. All 8 request; each owner drops its
        // request after one granted cycle.
        do_reset();
        req = 8'hFF;
        repeat (20) begin
            tick("t3");
            if (vld_w[0]) begin
                seq.push_back(int'(idx_w[0]));
                req = 8'hFF & ~(8'h01 << idx_w[0]);
            end else begin
                req = 8'hFF;
            end
        end
        chk("t3_count", 32'(seq.size() >= 9), 32'd1);
        for (int k = 0; k < 9 && k < seq.size(); k++)
            chk("t3_order", 32'(seq[k]), 32'(k % 8));
        req = 8'h00;
        repeat (2) tick("t3_end");

        // T4: a lone requester held forever is revoked by the limit and re-granted.
        req = 8'h20;
        repeat (40) tick("t4");
        req = 8'h00;
        repeat (2) tick("t4_end");

        // T5: an asynchronous reset in the middle of a cycle clears the grant at once.
        req = 8'h08;
        repeat (3) tick("t5_pre");
        @(posedge clk);
        for (int m = 0; m < 3; m++) model_step(m, req);
        #3;
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < 3; m++) begin
            chk("t5_async_gnt", 32'(gnt_w[m]), 32'd0);
            chk("t5_async_idx", 32'(idx_w[m]), 32'd0);
            chk("t5_async_vld", 32'(vld_w[m]), 32'd0);
        end
        model_reset();
        #1;
        rst_n = 1'b1;
        req = 8'h18;
        repeat (2) tick("t5_post");
        req = 8'h00;
        repeat (2) tick("t5_end");

        // T6: with no limit, the grant holds past hold-counter saturation.
        req = 8'h40;
        repeat (300) tick("t6");
        req = 8'h00;
        repeat (2) tick("t6_end");

        // Random traffic against the model. Requests are sticky so that
        // holds, releases and limit revocations all occur.
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
